// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory read port, redirect input and the
// valid/ready instruction stream towards decode.
interface instr_fetch_if #(
   parameter int PC_WIDTH    = 16,
   parameter int INSTR_WIDTH = 32
);
   logic                   imem_rd_en;
   logic [PC_WIDTH-1:0]    imem_addr;
   logic [INSTR_WIDTH-1:0] imem_rdata;
   logic                   redirect_valid;
   logic [PC_WIDTH-1:0]    redirect_pc;
   logic                   instr_valid;
   logic                   instr_ready;
   logic [INSTR_WIDTH-1:0] instr;
   logic [PC_WIDTH-1:0]    instr_pc;
   logic                   halted;

   modport master (
      output imem_rd_en, imem_addr, instr_valid, instr, instr_pc, halted,
      input  imem_rdata, redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_rd_en, imem_addr, instr_valid, instr, instr_pc, halted,
      output imem_rdata, redirect_valid, redirect_pc, instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory and buffers returned words in a 2-entry FIFO whose head
// feeds decode. Supports redirect with flush and stops after a HALT opcode.
module instr_fetch #(
   parameter int               PC_WIDTH    = 16,
   parameter int               INSTR_WIDTH = 32,
   parameter logic [15:0]      RESET_PC    = 16'h0000,
   parameter logic [5:0]       HALT_OP     = 6'b111110
) (
   input  logic            clk,
   input  logic            rst,
   instr_fetch_if.master   bus
);

   typedef enum logic [0:0] {S_FETCH, S_HALT} state_t;

   state_t                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic                   inflight_q, inflight_d;
   logic [PC_WIDTH-1:0]    inflight_pc_q, inflight_pc_d;
   logic [1:0]             count_q, count_d;
   logic [INSTR_WIDTH-1:0] head_data_q, head_data_d;
   logic [PC_WIDTH-1:0]    head_pc_q, head_pc_d;
   logic [INSTR_WIDTH-1:0] tail_data_q, tail_data_d;
   logic [PC_WIDTH-1:0]    tail_pc_q, tail_pc_d;

   logic                   pop;
   logic                   push;
   logic                   issue;
   logic                   halt_accept;
   logic                   flush;
   logic [1:0]             slots_used;

   // Handshake, issue and output decode; the pop-adjusted slot count lets a
   // full FIFO that is being drained start a new read in the same cycle.
   always_comb begin
      bus.instr_valid = (count_q != 2'd0) && (state_q == S_FETCH);
      bus.instr       = head_data_q;
      bus.instr_pc    = head_pc_q;
      bus.halted      = (state_q == S_HALT);
      bus.imem_addr   = pc_q;
      pop             = bus.instr_valid && bus.instr_ready;
      halt_accept     = pop && !bus.redirect_valid &&
                        (head_data_q[INSTR_WIDTH-1 -: 6] == HALT_OP);
      flush           = bus.redirect_valid || halt_accept;
      push            = inflight_q && (state_q == S_FETCH) && !flush;
      slots_used      = count_q + {1'b0, inflight_q} - {1'b0, pop};
      issue           = rst && (state_q == S_FETCH) && !bus.redirect_valid &&
                        (slots_used < 2'd2);
      bus.imem_rd_en  = issue;
   end

   // Next-state logic for the FSM, PC, in-flight tracking and the FIFO.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      count_d       = count_q;
      head_data_d   = head_data_q;
      head_pc_d     = head_pc_q;
      tail_data_d   = tail_data_q;
      tail_pc_d     = tail_pc_q;

      if (bus.redirect_valid) begin
         state_d = S_FETCH;
      end else if (halt_accept) begin
         state_d = S_HALT;
      end

      if (bus.redirect_valid) begin
         pc_d = bus.redirect_pc;
      end else if (issue) begin
         pc_d = pc_q + PC_WIDTH'(1);
      end

      if (issue) begin
         inflight_pc_d = pc_q;
      end

      if (flush) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (count_q == 2'd2) begin
                  head_data_d = tail_data_q;
                  head_pc_d   = tail_pc_q;
                  tail_data_d = bus.imem_rdata;
                  tail_pc_d   = inflight_pc_q;
               end else begin
                  head_data_d = bus.imem_rdata;
                  head_pc_d   = inflight_pc_q;
               end
            end
            2'b01: begin
               head_data_d = tail_data_q;
               head_pc_d   = tail_pc_q;
               count_d     = count_q - 2'd1;
            end
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_data_d = bus.imem_rdata;
                  head_pc_d   = inflight_pc_q;
               end else begin
                  tail_data_d = bus.imem_rdata;
                  tail_pc_d   = inflight_pc_q;
               end
               count_d = count_q + 2'd1;
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end
   end

   // State register with synchronous active-low reset dropping all buffered and in-flight data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_FETCH;
         pc_q          <= PC_WIDTH'(RESET_PC);
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         count_q       <= 2'd0;
         head_data_q   <= '0;
         head_pc_q     <= '0;
         tail_data_q   <= '0;
         tail_pc_q     <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         count_q       <= count_d;
         head_data_q   <= head_data_d;
         head_pc_q     <= head_pc_d;
         tail_data_q   <= tail_data_d;
         tail_pc_q     <= tail_pc_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, decode stall, redirect/flush,
// PC wrap, HALT and mid-stream reset, against a 1-cycle memory model.
module tb_instr_fetch;

   logic clk;
   logic rst;
   logic halt_en;
   int   checks;
   int   errors;

   instr_fetch_if #(.PC_WIDTH(16), .INSTR_WIDTH(32)) bus ();

   instr_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      if (halt_en && (a == 16'd3)) return {6'b111110, 26'd3};
      return {16'd0, a} + 32'h100;
   endfunction

   // Synchronous instruction memory: data for a read appears one cycle later.
   always @(posedge clk) begin
      bus.imem_rdata <= bus.imem_rd_en ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic r, input logic rdy, input logic rv, input logic [15:0] rpc);
      rst                = r;
      bus.instr_ready    = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_en"},  bus.imem_rd_en,  1'b0);
      chk({tag, "_addr"},   bus.imem_addr,   16'h0000);
      chk({tag, "_valid"},  bus.instr_valid, 1'b0);
      chk({tag, "_instr"},  bus.instr,       32'h0);
      chk({tag, "_pc"},     bus.instr_pc,    16'h0000);
      chk({tag, "_halted"}, bus.halted,      1'b0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      halt_en = 1'b0;
      rst                = 1'b0;
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 16'h0000;

      // Test 1: reset, then streaming at one instruction per cycle
      tick();
      chk_reset_outputs("t1_reset");
      set_in(1'b1, 1'b1, 1'b0, 16'h0000);
      chk("t1_c1_rd_en", bus.imem_rd_en, 1'b1);
      chk("t1_c1_addr",  bus.imem_addr,  16'h0000);
      tick();
      chk("t1_c2_valid", bus.instr_valid, 1'b0);
      chk("t1_c2_addr",  bus.imem_addr,   16'h0001);
      tick();
      for (int k = 0; k < 6; k++) begin
         chk("t1_valid", bus.instr_valid, 1'b1);
         chk("t1_instr", bus.instr,       32'h100 + 32'(k));
         chk("t1_pc",    bus.instr_pc,    16'(k));
         chk("t1_addr",  bus.imem_addr,   16'(k + 2));
         tick();
      end

      // Test 2: decode stalls for 5 cycles, FIFO fills and reads stop
      set_in(1'b1, 1'b0, 1'b0, 16'h0000);
      chk("t2_d0_rd_en", bus.imem_rd_en, 1'b0);
      chk("t2_d0_pc",    bus.instr_pc,   16'h0006);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t2_hold_rd_en", bus.imem_rd_en,  1'b0);
         chk("t2_hold_valid", bus.instr_valid, 1'b1);
         chk("t2_hold_pc",    bus.instr_pc,    16'h0006);
         chk("t2_hold_instr", bus.instr,       32'h106);
      end
      set_in(1'b1, 1'b1, 1'b0, 16'h0000);
      chk("t2_release_rd_en", bus.imem_rd_en, 1'b1);
      chk("t2_release_addr",  bus.imem_addr,  16'h0008);
      chk("t2_release_pc",    bus.instr_pc,   16'h0006);
      for (int k = 7; k <= 10; k++) begin
         tick();
         chk("t2_resume_valid", bus.instr_valid, 1'b1);
         chk("t2_resume_pc",    bus.instr_pc,    16'(k));
         chk("t2_resume_instr", bus.instr,       32'h100 + 32'(k));
      end

      // Test 3: redirect with a buffered word and a read returning
      set_in(1'b1, 1'b0, 1'b1, 16'h0040);
      chk("t3_redirect_no_issue", bus.imem_rd_en, 1'b0);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 16'h0000);
      chk("t3_r1_valid", bus.instr_valid, 1'b0);
      chk("t3_r1_rd_en", bus.imem_rd_en,  1'b1);
      chk("t3_r1_addr",  bus.imem_addr,   16'h0040);
      tick();
      chk("t3_r2_valid", bus.instr_valid, 1'b0);
      chk("t3_r2_addr",  bus.imem_addr,   16'h0041);
      tick();
      chk("t3_r3_valid", bus.instr_valid, 1'b1);
      chk("t3_r3_pc",    bus.instr_pc,    16'h0040);
      chk("t3_r3_instr", bus.instr,       32'h140);
      tick();
      chk("t3_r4_pc",    bus.instr_pc,    16'h0041);
      chk("t3_r4_instr", bus.instr,       32'h141);

      // Test 4: PC wrap from 0xFFFE
      set_in(1'b1, 1'b1, 1'b1, 16'hFFFE);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 16'h0000);
      chk("t4_addr_fffe", bus.imem_addr, 16'hFFFE);
      tick();
      chk("t4_addr_ffff", bus.imem_addr, 16'hFFFF);
      tick();
      chk("t4_addr_wrap", bus.imem_addr, 16'h0000);
      chk("t4_pc_fffe",   bus.instr_pc,  16'hFFFE);
      chk("t4_instr_fffe", bus.instr,    32'h0001_00FE);
      tick();
      chk("t4_pc_ffff",   bus.instr_pc,  16'hFFFF);
      chk("t4_instr_ffff", bus.instr,    32'h0001_00FF);
      tick();
      chk("t4_pc_0000",   bus.instr_pc,  16'h0000);
      chk("t4_instr_0000", bus.instr,    32'h100);

      // Test 5: HALT at address 3, then resume by redirect
      halt_en = 1'b1;
      set_in(1'b1, 1'b1, 1'b1, 16'h0000);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 16'h0000);
      tick();
      tick();
      chk("t5_pc0", bus.instr_pc, 16'h0000);
      tick();
      chk("t5_pc1", bus.instr_pc, 16'h0001);
      tick();
      chk("t5_pc2", bus.instr_pc, 16'h0002);
      tick();
      chk("t5_pc3",        bus.instr_pc, 16'h0003);
      chk("t5_halt_instr", bus.instr,    32'hF800_0003);
      chk("t5_not_halted", bus.halted,   1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_halted",   bus.halted,      1'b1);
         chk("t5_no_valid", bus.instr_valid, 1'b0);
         chk("t5_no_read",  bus.imem_rd_en,  1'b0);
      end
      set_in(1'b1, 1'b1, 1'b1, 16'h0010);
      chk("t5_redir_still_halted", bus.halted,     1'b1);
      chk("t5_redir_no_read",      bus.imem_rd_en, 1'b0);
      tick();
      set_in(1'b1, 1'b1, 1'b0, 16'h0000);
      chk("t5_resume_halted", bus.halted,     1'b0);
      chk("t5_resume_rd_en",  bus.imem_rd_en, 1'b1);
      chk("t5_resume_addr",   bus.imem_addr,  16'h0010);
      tick();
      tick();
      chk("t5_resume_valid", bus.instr_valid, 1'b1);
      chk("t5_resume_pc",    bus.instr_pc,    16'h0010);
      chk("t5_resume_instr", bus.instr,       32'h110);

      // Test 6: full FIFO, drain-and-issue, then reset mid-stream
      set_in(1'b1, 1'b0, 1'b0, 16'h0000);
      tick();
      chk("t6_full_pc",       bus.instr_pc,   16'h0010);
      chk("t6_full_no_issue", bus.imem_rd_en, 1'b0);
      set_in(1'b1, 1'b1, 1'b0, 16'h0000);
      chk("t6_full_pop_issue", bus.imem_rd_en, 1'b1);
      chk("t6_full_pop_addr",  bus.imem_addr,  16'h0012);
      tick();
      chk("t6_pre_reset_pc", bus.instr_pc, 16'h0011);
      set_in(1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      chk_reset_outputs("t6_reset");
      set_in(1'b1, 1'b1, 1'b0, 16'h0000);
      chk("t6_c1_rd_en", bus.imem_rd_en, 1'b1);
      chk("t6_c1_addr",  bus.imem_addr,  16'h0000);
      tick();
      chk("t6_c2_valid", bus.instr_valid, 1'b0);
      tick();
      chk("t6_c3_valid", bus.instr_valid, 1'b1);
      chk("t6_c3_pc",    bus.instr_pc,    16'h0000);
      chk("t6_c3_instr", bus.instr,       32'h100);
      tick();
      chk("t6_c4_pc",    bus.instr_pc,    16'h0001);
      chk("t6_c4_instr", bus.instr,       32'h101);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
